// File: rtl/match_pkg.sv
// Shared types and defaults for the match scheduler slice.
// Optional build macro used by the top: MATCH_TIMEOUT_EN (WAIT-state watchdog).
package match_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } match_state_e;

   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/match_scheduler_if.sv
// Requester and matcher signals of the match scheduler.
// The master modport is the scheduler; slave is the requesters plus matcher.
interface match_scheduler_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]            gnt;
   logic                          m_cs;
   logic [ADDR_WIDTH-1:0]         m_start_addr;
   logic                          m_done;
   logic                          m_equal;
   logic                          m_clr_n;
   logic                          resp_valid;
   logic [ID_W-1:0]               resp_id;
   logic                          resp_hit;
   logic                          resp_timeout;
   logic                          busy;

   modport master (
      input  req, req_addr, m_done, m_equal,
      output gnt, m_cs, m_start_addr, m_clr_n,
             resp_valid, resp_id, resp_hit, resp_timeout, busy
   );

   modport slave (
      output req, req_addr, m_done, m_equal,
      input  gnt, m_cs, m_start_addr, m_clr_n,
             resp_valid, resp_id, resp_hit, resp_timeout, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scan starts at ptr and wraps past NUM_REQ-1.
// Returns the one-hot winner, its index and whether anything was requesting.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               valid
);

   int cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = (int'(ptr) + off) % NUM_REQ;
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            grant[cand] = 1'b1;
            idx         = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/match_scheduler.sv
// Shares one string matcher between NUM_REQ requesters: IDLE -> ISSUE -> WAIT -> RESP.
// Define MATCH_TIMEOUT_EN to add a WAIT watchdog that aborts after TIMEOUT_CYCLES.
module match_scheduler
   import match_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   match_scheduler_if.master bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ISSUE = ISSUE;
   localparam logic [1:0] S_WAIT  = WAIT;
   localparam logic [1:0] S_RESP  = RESP;

   logic [1:0]            state;
   logic [ID_W-1:0]       ptr;
   logic [ID_W-1:0]       cur_id;
   logic [NUM_REQ-1:0]    cur_gnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ID_W-1:0]       resp_id_q;
   logic                  resp_hit_q;

   logic [NUM_REQ-1:0]    arb_gnt;
   logic [ID_W-1:0]       arb_idx;
   logic                  arb_valid;
   logic                  timed_out;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req   (bus.req),
      .ptr   (ptr),
      .grant (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

`ifdef MATCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] wait_cnt;
   logic             resp_timeout_q;

   assign timed_out = (state == S_WAIT) && !bus.m_done &&
                      (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counter sits at zero outside WAIT, so every WAIT entry starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt       <= '0;
         resp_timeout_q <= 1'b0;
      end else begin
         if (state != S_WAIT)
            wait_cnt <= '0;
         else if (!timed_out)
            wait_cnt <= wait_cnt + 1'b1;
         if (state == S_WAIT && (bus.m_done || timed_out))
            resp_timeout_q <= timed_out;
      end
   end

   assign bus.resp_timeout = resp_timeout_q;
`else
   logic unused_timeout;

   assign unused_timeout   = ^TIMEOUT_CYCLES;
   assign timed_out        = 1'b0;
   assign bus.resp_timeout = 1'b0;
`endif

   // The winner's id, one-hot grant and address are latched in IDLE so later
   // req/req_addr activity cannot disturb a lookup already in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ptr        <= '0;
         cur_id     <= '0;
         cur_gnt    <= '0;
         addr_q     <= '0;
         resp_id_q  <= '0;
         resp_hit_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (arb_valid) begin
                  cur_id  <= arb_idx;
                  cur_gnt <= arb_gnt;
                  addr_q  <= bus.req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                  ptr     <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (bus.m_done || timed_out) begin
                  resp_hit_q <= bus.m_done & bus.m_equal;
                  resp_id_q  <= cur_id;
                  state      <= S_RESP;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.gnt          = (state == S_ISSUE) ? cur_gnt : '0;
   assign bus.m_cs         = (state == S_ISSUE);
   assign bus.m_start_addr = addr_q;
   assign bus.m_clr_n      = (state != S_RESP);
   assign bus.resp_valid   = (state == S_RESP);
   assign bus.resp_id      = resp_id_q;
   assign bus.resp_hit     = resp_hit_q;
   assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_match_scheduler.sv
// Directed bench for match_scheduler: reset, fairness, hit/miss, dropped requests,
// watchdog behaviour (with or without MATCH_TIMEOUT_EN) and reset during WAIT.
module tb_match_scheduler;

   localparam int NUM_REQ        = 4;
   localparam int ADDR_WIDTH     = 4;
   localparam int TIMEOUT_CYCLES = 8;

   logic clk;
   logic rst_n;

   int errors      = 0;
   int checks      = 0;
   int gnt_pulses  = 0;
   int resp_pulses = 0;

   logic [3:0] obs_gnt, obs_gnt_next, obs_addr;
   logic [1:0] obs_id;
   logic       obs_hit, obs_to, obs_clr, obs_clr_after, obs_valid_after;
   int         obs_lat;

   int         fair_delay [5] = '{0, 1, 3, 2, 1};
   int         fair_lat   [5] = '{2, 2, 4, 3, 2};
   logic       fair_eq    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [3:0] fair_gnt   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] fair_addr  [5] = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h3};
   logic [1:0] fair_id    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   match_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   match_scheduler #(
      .NUM_REQ        (NUM_REQ),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (|bus.gnt) gnt_pulses++;
      if (bus.resp_valid) resp_pulses++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Serves one lookup as the matcher would: m_done rises done_delay cycles after m_cs.
   task automatic applyStimulus(input int done_delay, input logic equal,
                                input logic drop_req, input logic [3:0] inject);
      int n;
      n = 0;
      while (bus.m_cs !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("m_cs_seen", 32'(bus.m_cs), 32'd1);
      obs_gnt  = bus.gnt;
      obs_addr = bus.m_start_addr;
      if (drop_req) bus.req = bus.req & ~bus.gnt;
      obs_lat = 0;
      if (done_delay == 0) begin
         bus.m_done  = 1'b1;
         bus.m_equal = equal;
      end
      while (bus.resp_valid !== 1'b1 && obs_lat < 60) begin
         @(negedge clk);
         obs_lat++;
         if (obs_lat == 1) begin
            obs_gnt_next = bus.gnt;
            bus.req      = bus.req | inject;
         end
         if (obs_lat == 2) bus.req = bus.req & ~inject;
         if (obs_lat == done_delay) begin
            bus.m_done  = 1'b1;
            bus.m_equal = equal;
         end
      end
      checkOutput("resp_seen", 32'(bus.resp_valid), 32'd1);
      obs_id      = bus.resp_id;
      obs_hit     = bus.resp_hit;
      obs_to      = bus.resp_timeout;
      obs_clr     = bus.m_clr_n;
      bus.m_done  = 1'b0;
      bus.m_equal = 1'b0;
      @(negedge clk);
      obs_clr_after   = bus.m_clr_n;
      obs_valid_after = bus.resp_valid;
   endtask

   task automatic expectLookup(input string tag, input logic [3:0] e_gnt,
                               input logic [3:0] e_addr, input logic [1:0] e_id,
                               input logic e_hit, input logic e_to, input int e_lat);
      checkOutput({tag, ".gnt"},        32'(obs_gnt),         32'(e_gnt));
      checkOutput({tag, ".addr"},       32'(obs_addr),        32'(e_addr));
      checkOutput({tag, ".gnt_pulse"},  32'(obs_gnt_next),    32'd0);
      checkOutput({tag, ".latency"},    32'(obs_lat),         32'(e_lat));
      checkOutput({tag, ".resp_id"},    32'(obs_id),          32'(e_id));
      checkOutput({tag, ".resp_hit"},   32'(obs_hit),         32'(e_hit));
      checkOutput({tag, ".timeout"},    32'(obs_to),          32'(e_to));
      checkOutput({tag, ".clr_low"},    32'(obs_clr),         32'd0);
      checkOutput({tag, ".clr_high"},   32'(obs_clr_after),   32'd1);
      checkOutput({tag, ".valid_once"}, 32'(obs_valid_after), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int g0, r0, n;
      bus.req      = '0;
      bus.req_addr = 16'hA5C3;
      bus.m_done   = 1'b0;
      bus.m_equal  = 1'b0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rst.gnt",          32'(bus.gnt),          32'd0);
      checkOutput("rst.m_cs",         32'(bus.m_cs),         32'd0);
      checkOutput("rst.m_clr_n",      32'(bus.m_clr_n),      32'd1);
      checkOutput("rst.m_start_addr", 32'(bus.m_start_addr), 32'd0);
      checkOutput("rst.resp_valid",   32'(bus.resp_valid),   32'd0);
      checkOutput("rst.resp_id",      32'(bus.resp_id),      32'd0);
      checkOutput("rst.resp_hit",     32'(bus.resp_hit),     32'd0);
      checkOutput("rst.resp_timeout", 32'(bus.resp_timeout), 32'd0);
      checkOutput("rst.busy",         32'(bus.busy),         32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] fairness with all requesters held");
      g0 = gnt_pulses;
      r0 = resp_pulses;
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(fair_delay[i], fair_eq[i], 1'b0, 4'b0000);
         expectLookup($sformatf("fair%0d", i), fair_gnt[i], fair_addr[i], fair_id[i],
                      fair_eq[i], 1'b0, fair_lat[i]);
      end
      bus.req = '0;
      @(negedge clk);
      checkOutput("fair.gnt_count",  32'(gnt_pulses - g0),  32'd5);
      checkOutput("fair.resp_count", 32'(resp_pulses - r0), 32'd5);
      checkOutput("fair.idle_busy",  32'(bus.busy),         32'd0);

      $display("[TB] single request on requester 2");
      bus.req = 4'b0100;
      applyStimulus(6, 1'b1, 1'b1, 4'b0000);
      expectLookup("single", 4'b0100, 4'h5, 2'd2, 1'b1, 1'b0, 7);
      repeat (3) @(negedge clk);
      checkOutput("held.resp_id",  32'(bus.resp_id),  32'd2);
      checkOutput("held.resp_hit", 32'(bus.resp_hit), 32'd1);
      checkOutput("held.busy",     32'(bus.busy),     32'd0);

      $display("[TB] miss with a request glitch while busy");
      bus.req = 4'b1000;
      applyStimulus(3, 1'b0, 1'b1, 4'b0001);
      expectLookup("miss", 4'b1000, 4'hA, 2'd3, 1'b0, 1'b0, 4);
      bus.req = 4'b0100;
      applyStimulus(2, 1'b1, 1'b1, 4'b0000);
      expectLookup("after_drop", 4'b0100, 4'h5, 2'd2, 1'b1, 1'b0, 3);

`ifdef MATCH_TIMEOUT_EN
      $display("[TB] watchdog abort");
      bus.req = 4'b0010;
      applyStimulus(1000, 1'b1, 1'b1, 4'b0000);
      expectLookup("timeout", 4'b0010, 4'hC, 2'd1, 1'b0, 1'b1, 9);
      bus.req = 4'b0010;
      n = 0;
      while (bus.m_cs !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait.m_cs_seen", 32'(bus.m_cs), 32'd1);
      bus.req = '0;
      @(negedge clk);
`else
      $display("[TB] WAIT with m_done held low");
      bus.req = 4'b0010;
      n = 0;
      while (bus.m_cs !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("to.m_cs_seen", 32'(bus.m_cs), 32'd1);
      bus.req = '0;
      r0 = resp_pulses;
      repeat (20) @(negedge clk);
      checkOutput("to.busy_held", 32'(bus.busy),         32'd1);
      checkOutput("to.no_resp",   32'(resp_pulses - r0), 32'd0);
`endif

      $display("[TB] reset during WAIT");
      checkOutput("wait.busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst.busy",         32'(bus.busy),         32'd0);
      checkOutput("mid_rst.gnt",          32'(bus.gnt),          32'd0);
      checkOutput("mid_rst.m_cs",         32'(bus.m_cs),         32'd0);
      checkOutput("mid_rst.m_clr_n",      32'(bus.m_clr_n),      32'd1);
      checkOutput("mid_rst.m_start_addr", 32'(bus.m_start_addr), 32'd0);
      checkOutput("mid_rst.resp_valid",   32'(bus.resp_valid),   32'd0);
      checkOutput("mid_rst.resp_id",      32'(bus.resp_id),      32'd0);
      checkOutput("mid_rst.resp_hit",     32'(bus.resp_hit),     32'd0);
      checkOutput("mid_rst.resp_timeout", 32'(bus.resp_timeout), 32'd0);
      r0 = resp_pulses;
      bus.req = 4'b1111;
      repeat (2) @(negedge clk);
      checkOutput("mid_rst.no_resp", 32'(resp_pulses - r0), 32'd0);
      rst_n = 1'b1;
      applyStimulus(1, 1'b1, 1'b1, 4'b0000);
      bus.req = '0;
      expectLookup("post_rst", 4'b0001, 4'h3, 2'd0, 1'b1, 1'b0, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/match_scheduler.md
MATCH_SCHEDULER -- requirements
Module: match_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one matcher (2..8).
REQ-002 Parameter ADDR_WIDTH, default 4: width of the vocab start address handed to the matcher.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: WAIT-state watchdog limit (used only with MATCH_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester lookup request, held high until matching gnt bit.
REQ-007 req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester vocab start address, slice i belongs to req[i].
REQ-008 gnt  output  NUM_REQ  one-hot grant, one-cycle pulse.
REQ-009 m_cs  output  1  matcher start strobe, one-cycle pulse.
REQ-010 m_start_addr  output  ADDR_WIDTH  start address for the matcher, stable from ISSUE until leaving RESP.
REQ-011 m_done  input  1  matcher done flag (level).
REQ-012 m_equal  input  1  matcher hit flag, valid while m_done=1.
REQ-013 m_clr_n  output  1  active-low matcher clear, one-cycle low pulse returning the matcher to its idle state.
REQ-014 resp_valid  output  1  one-cycle response strobe.
REQ-015 resp_id  output  $clog2(NUM_REQ)  requester index of the response.
REQ-016 resp_hit  output  1  lookup hit.
REQ-017 resp_timeout  output  1  lookup aborted by watchdog.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if any req bit is high, latch the round-robin winner id and its req_addr slice, then go to ISSUE; otherwise stay.
REQ-021 ISSUE (one cycle): gnt[id]=1, m_cs=1; then go to WAIT.
REQ-022 WAIT: when m_done=1, capture m_equal into resp_hit and go to RESP; otherwise stay.
REQ-023 RESP (one cycle): resp_valid=1, m_clr_n=0, resp_id=latched id; then go to IDLE.
REQ-024 Arbitration: round-robin; the search starts at the index after the last granted requester and wraps from NUM_REQ-1 to 0; priority pointer resets to 0 (requester 0 highest).
REQ-025 Pointer update: the pointer changes only on a grant.
REQ-026 Request sampling: req changes outside IDLE are ignored.
REQ-027 Deasserted req: a req dropped before its grant is never granted.
REQ-028 Minimum latency: from req sampled in IDLE to resp_valid is 3 cycles plus the cycles m_done stays low in WAIT.
REQ-029 Back-to-back lookups: consecutive lookups are spaced at least 4 cycles apart.
REQ-030 Held outputs: resp_hit, resp_id and resp_timeout hold their values until the next RESP.
REQ-031 m_done already high on WAIT entry: the FSM proceeds to RESP the next cycle.

Reset
REQ-032 On rst_n low, asynchronously: state=IDLE, pointer=0, gnt=0, m_cs=0, m_clr_n=1, m_start_addr=0, resp_valid=0, resp_id=0, resp_hit=0, resp_timeout=0, busy=0.
REQ-033 Reset mid-lookup discards the transaction with no response; the matcher is reset by the same rst_n.

Configuration
REQ-034 With MATCH_TIMEOUT_EN defined:
- A WAIT-cycle counter (clear on WAIT entry) forces RESP with resp_timeout=1 and resp_hit=0 when it reaches TIMEOUT_CYCLES-1 with m_done low.
- resp_timeout=0 on normal completion.
REQ-035 Without MATCH_TIMEOUT_EN: no counter is compiled, WAIT waits indefinitely, and resp_timeout is tied 0.

Structure
REQ-036 Package match_pkg holds the state enum (IDLE/ISSUE/WAIT/RESP) and the default TIMEOUT_CYCLES constant.
REQ-037 Round-robin selection is a sub-module rr_arbiter (inputs: req vector, pointer; output: one-hot winner plus index).

Verification
REQ-038 Single request: req=4'b0100, addr2=5, m_done high 6 cycles after m_cs, m_equal=1 -> gnt=4'b0100, m_start_addr=5, resp_valid with resp_id=2 and resp_hit=1.
REQ-039 Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0, each grant followed by exactly one resp_valid.
REQ-040 Miss: m_equal=0 at m_done -> resp_hit=0, m_clr_n low exactly one cycle, concurrent with resp_valid.
REQ-041 Timeout (MATCH_TIMEOUT_EN, TIMEOUT_CYCLES=8), m_done held low -> resp_valid with resp_timeout=1 and resp_hit=0 exactly 8 cycles after WAIT entry; without the macro, busy stays high.
REQ-042 rst_n pulsed low in WAIT -> all outputs at reset values immediately, no resp_valid, and the next req is granted from requester 0 priority.
